// File: rtl/vlc_frame_rx_ctrl.sv
`timescale 1ns/1ps
// vlc_frame_rx_ctrl: hunts SOF, checks length and checksum, buffers good frames and drains them over valid/ready
module vlc_frame_rx_ctrl #(
  parameter int MAX_LEN = 32,
  parameter int TIMEOUT = 2000,
  parameter logic [7:0] SOF = 8'hA5
) (
  input  logic        clk16x,
  input  logic        resetn,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  input  logic        recv_err_i,
  output logic [7:0]  out_data_o,
  output logic        out_valid_o,
  output logic        out_last_o,
  input  logic        out_ready_i,
  output logic        frame_ok_o,
  output logic        frame_err_o,
  output logic [1:0]  err_code_o,
  output logic        overrun_o,
  output logic [15:0] ok_count_o,
  output logic [15:0] err_count_o
);
  localparam int PW = $clog2(MAX_LEN + 1);
  localparam int AW = $clog2(MAX_LEN);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {sIdle, sLen, sPayload, sCsum, sDrain} state_t;
  state_t state, nextState;
  logic [PW-1:0] lenReg, wrPtr, rdPtr;
  logic [7:0] csum;
  logic [TW-1:0] idleCnt;
  logic [7:0] bufMem [MAX_LEN];
  logic inFrame, accept, lenBad, lastWr, rdLast, handshake, timeUp, abort, good;
  logic [1:0] abortCode;
  assign inFrame = state inside {sLen, sPayload, sCsum};
  assign accept = byte_valid_i && !recv_err_i;
  assign lenBad = byte_i == 8'd0 || byte_i > 8'(MAX_LEN);
  assign lastWr = wrPtr + PW'(1) == lenReg;
  assign rdLast = rdPtr == lenReg - PW'(1);
  assign handshake = out_valid_o && out_ready_i;
  assign timeUp = idleCnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk16x or negedge resetn)
    if (!resetn) state <= sIdle;
    else state <= nextState;
  always_comb begin
    nextState = state;
    abort = 1'b0;
    abortCode = 2'd0;
    good = 1'b0;
    case (state)
      sIdle: nextState = (byte_valid_i && byte_i == SOF) ? sLen : sIdle;
      sLen: if (accept) begin
        nextState = lenBad ? sIdle : sPayload;
        abort = lenBad;
        abortCode = 2'd1;
      end
      sPayload: if (accept && lastWr) nextState = sCsum;
      sCsum: if (accept) begin
        good = byte_i == csum;
        abort = byte_i != csum;
        abortCode = 2'd2;
        nextState = good ? sDrain : sIdle;
      end
      sDrain: if (handshake && rdLast) nextState = sIdle;
      default: nextState = sIdle;
    endcase
    // a line error beats a same-cycle byte; a same-cycle byte beats the timeout
    if (inFrame && recv_err_i) begin
      abort = 1'b1;
      abortCode = 2'd0;
      good = 1'b0;
      nextState = sIdle;
    end else if (inFrame && !byte_valid_i && timeUp) begin
      abort = 1'b1;
      abortCode = 2'd3;
      nextState = sIdle;
    end
  end
  always_comb begin
    out_valid_o = state == sDrain;
    out_data_o = out_valid_o ? bufMem[rdPtr[AW-1:0]] : 8'd0;
    out_last_o = out_valid_o && rdLast;
  end
  always_ff @(posedge clk16x or negedge resetn) begin
    if (!resetn) begin
      lenReg <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      csum <= '0;
      idleCnt <= '0;
      frame_ok_o <= 1'b0;
      frame_err_o <= 1'b0;
      err_code_o <= '0;
      overrun_o <= 1'b0;
      ok_count_o <= '0;
      err_count_o <= '0;
    end else begin
      frame_ok_o <= good;
      frame_err_o <= abort;
      overrun_o <= state == sDrain && byte_valid_i;
      idleCnt <= (inFrame && !byte_valid_i && !abort) ? idleCnt + TW'(1) : '0;
      if (abort) err_code_o <= abortCode;
      if (good && ok_count_o != 16'hFFFF) ok_count_o <= ok_count_o + 16'd1;
      if (abort && err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
      if (state == sLen && accept && !lenBad) begin
        lenReg <= byte_i[PW-1:0];
        csum <= byte_i;
        wrPtr <= '0;
      end
      if (state == sPayload && accept) begin
        csum <= csum ^ byte_i;
        wrPtr <= wrPtr + PW'(1);
      end
      if (good) rdPtr <= '0;
      if (handshake) rdPtr <= rdPtr + PW'(1);
    end
  end
  always_ff @(posedge clk16x)
    if (state == sPayload && accept) bufMem[wrPtr[AW-1:0]] <= byte_i;
endmodule

// File: tb/tb_vlc_frame_rx_ctrl.sv
`timescale 1ns/1ps
// tb_vlc_frame_rx_ctrl: directed and random frames checked against a frame-level reference model
module tb_vlc_frame_rx_ctrl;
  localparam int MAX_LEN = 32;
  localparam int TIMEOUT = 2000;
  localparam logic [7:0] SOF = 8'hA5;
  typedef logic [7:0] bq_t[$];
  logic clk16x = 1'b0;
  logic resetn = 1'b0;
  logic [7:0] byte_i = '0;
  logic byte_valid_i = 1'b0, recv_err_i = 1'b0, out_ready_i = 1'b0;
  logic [7:0] out_data_o;
  logic out_valid_o, out_last_o, frame_ok_o, frame_err_o, overrun_o;
  logic [1:0] err_code_o;
  logic [15:0] ok_count_o, err_count_o;
  int vecs = 0, errs = 0;
  int okPulses = 0, errPulses = 0, ovrPulses = 0, validCycles = 0;
  int expOk = 0, expErr = 0;
  logic [1:0] expCode = 2'd0;
  logic [8:0] capQ[$];

  vlc_frame_rx_ctrl #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT), .SOF(SOF)) dut (
    .clk16x(clk16x), .resetn(resetn), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .recv_err_i(recv_err_i), .out_data_o(out_data_o), .out_valid_o(out_valid_o),
    .out_last_o(out_last_o), .out_ready_i(out_ready_i), .frame_ok_o(frame_ok_o),
    .frame_err_o(frame_err_o), .err_code_o(err_code_o), .overrun_o(overrun_o),
    .ok_count_o(ok_count_o), .err_count_o(err_count_o)
  );

  always #5 clk16x = ~clk16x;

  always @(negedge clk16x) if (resetn) begin
    if (out_valid_o && out_ready_i) capQ.push_back({out_last_o, out_data_o});
    okPulses += int'(frame_ok_o);
    errPulses += int'(frame_err_o);
    ovrPulses += int'(overrun_o);
    validCycles += int'(out_valid_o);
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1);
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk16x); #1; end
  endtask

  task automatic sendByte(logic [7:0] b);
    byte_i = b;
    byte_valid_i = 1'b1;
    @(posedge clk16x); #1;
    byte_valid_i = 1'b0;
  endtask

  task automatic sendErr();
    recv_err_i = 1'b1;
    @(posedge clk16x); #1;
    recv_err_i = 1'b0;
  endtask

  function automatic logic [7:0] xsum(bq_t p);
    logic [7:0] s = 8'(p.size());
    foreach (p[i]) s ^= p[i];
    return s;
  endfunction

  task automatic sendFrame(bq_t p, logic [7:0] adj);
    sendByte(SOF);
    sendByte(8'(p.size()));
    foreach (p[i]) sendByte(p[i]);
    sendByte(xsum(p) ^ adj);
  endtask

  task automatic clearMon();
    capQ.delete();
    okPulses = 0;
    errPulses = 0;
    ovrPulses = 0;
    validCycles = 0;
  endtask

  task automatic drainAll(bit rnd);
    int n = 0;
    while (out_valid_o && n < 3000) begin
      out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk16x); #1;
      n++;
    end
    out_ready_i = 1'b1;
    chk("drain_done", out_valid_o, 0);
  endtask

  task automatic checkStream(string tag, bq_t exp);
    chk({tag, "_count"}, capQ.size(), exp.size());
    for (int i = 0; i < exp.size() && i < capQ.size(); i++) begin
      chk({tag, "_data"}, capQ[i][7:0], exp[i]);
      chk({tag, "_last"}, capQ[i][8], i == exp.size() - 1);
    end
  endtask

  task automatic chkQuiet(string tag);
    chk({tag, "_valid"}, out_valid_o, 0);
    chk({tag, "_data"}, out_data_o, 0);
    chk({tag, "_last"}, out_last_o, 0);
    chk({tag, "_ok"}, frame_ok_o, 0);
    chk({tag, "_err"}, frame_err_o, 0);
    chk({tag, "_code"}, err_code_o, 0);
    chk({tag, "_ovr"}, overrun_o, 0);
    chk({tag, "_okcnt"}, ok_count_o, 0);
    chk({tag, "_errcnt"}, err_count_o, 0);
  endtask

  task automatic chkCounts(string tag);
    chk({tag, "_okcnt"}, ok_count_o, expOk);
    chk({tag, "_errcnt"}, err_count_o, expErr);
    chk({tag, "_code"}, err_code_o, expCode);
  endtask

  initial begin
    bq_t p, big;
    idle(3);
    chkQuiet("reset");
    resetn = 1'b1;
    out_ready_i = 1'b1;
    idle(2);

    // good frame with one-edge latency
    clearMon();
    p = '{8'h11, 8'h22, 8'h33};
    sendFrame(p, 8'h00);
    expOk++;
    chk("good_ok_latency", frame_ok_o, 1);
    chk("good_valid_latency", out_valid_o, 1);
    drainAll(0);
    checkStream("good", p);
    chk("good_okpulses", okPulses, 1);
    chkCounts("good");

    // backpressure plus a dropped byte during drain
    clearMon();
    out_ready_i = 1'b0;
    sendFrame(p, 8'h00);
    expOk++;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", out_data_o, 8'h11);
      chk("bp_valid", out_valid_o, 1);
      if (i == 2) sendByte(8'h55);
      else idle(1);
    end
    chk("bp_nothing_taken", capQ.size(), 0);
    drainAll(0);
    checkStream("bp", p);
    chk("bp_overrun", ovrPulses, 1);
    chkCounts("bp");

    // bad checksum
    clearMon();
    sendByte(SOF); sendByte(8'h02); sendByte(8'h01); sendByte(8'h02); sendByte(8'h00);
    expErr++;
    expCode = 2'd2;
    chk("csum_err_pulse", frame_err_o, 1);
    idle(3);
    chkCounts("csum");
    chk("csum_errpulses", errPulses, 1);
    chk("csum_no_valid", validCycles, 0);

    // length bounds
    sendByte(SOF); sendByte(8'h00);
    expErr++;
    expCode = 2'd1;
    chk("len0_err", frame_err_o, 1);
    chkCounts("len0");
    sendByte(SOF); sendByte(8'(MAX_LEN + 1));
    expErr++;
    chk("lenmax1_err", frame_err_o, 1);
    chkCounts("lenmax1");
    clearMon();
    big.delete();
    for (int i = 0; i < MAX_LEN; i++) big.push_back(8'(i * 7 + 1));
    sendFrame(big, 8'h00);
    expOk++;
    chk("lenmax_ok", frame_ok_o, 1);
    drainAll(1);
    checkStream("lenmax", big);
    chkCounts("lenmax");

    // timeout fires exactly after TIMEOUT idle cycles
    sendByte(SOF); sendByte(8'h04); sendByte(8'hAA);
    idle(TIMEOUT - 1);
    chk("to_not_early", frame_err_o, 0);
    chk("to_cnt_early", err_count_o, expErr);
    idle(1);
    expErr++;
    expCode = 2'd3;
    chk("to_fire", frame_err_o, 1);
    chkCounts("to");
    clearMon();
    p = '{8'h5A};
    sendFrame(p, 8'h00);
    expOk++;
    chk("to_resync_ok", frame_ok_o, 1);
    drainAll(0);
    checkStream("to_resync", p);

    // a byte in the cycle the timeout would fire keeps the frame alive
    clearMon();
    sendByte(SOF); sendByte(8'h02);
    idle(TIMEOUT - 1);
    sendByte(8'h33);
    chk("to_byte_wins", frame_err_o, 0);
    sendByte(8'h44); sendByte(8'h02 ^ 8'h33 ^ 8'h44);
    expOk++;
    chk("to_byte_wins_ok", frame_ok_o, 1);
    drainAll(0);
    p = '{8'h33, 8'h44};
    checkStream("to_edge", p);
    chkCounts("to_edge");

    // line error, then SOF on the very next cycle
    sendByte(SOF); sendByte(8'h02);
    sendErr();
    expErr++;
    expCode = 2'd0;
    chk("line_err", frame_err_o, 1);
    chkCounts("line");
    clearMon();
    p = '{8'h5B, 8'hC4};
    sendFrame(p, 8'h00);
    expOk++;
    chk("line_resync_ok", frame_ok_o, 1);
    drainAll(0);
    checkStream("line_resync", p);

    // line error with a simultaneous byte: error wins
    sendByte(SOF); sendByte(8'h02);
    recv_err_i = 1'b1;
    sendByte(8'h10);
    recv_err_i = 1'b0;
    expErr++;
    chk("simul_err", frame_err_o, 1);
    chkCounts("simul");

    // randomized frames against the frame-level model
    for (int f = 0; f < 25; f++) begin
      int kind, len;
      logic [7:0] adj;
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        logic [7:0] b = 8'($urandom);
        if (b == SOF) b = 8'h5A;
        recv_err_i = ($urandom_range(0, 3) == 0);
        sendByte(b);
        recv_err_i = 1'b0;
      end
      clearMon();
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        sendByte(SOF);
        sendByte(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
        expErr++;
        expCode = 2'd1;
        chk("rnd_len_err", frame_err_o, 1);
      end else begin
        len = $urandom_range(1, MAX_LEN);
        p.delete();
        for (int i = 0; i < len; i++) p.push_back(8'($urandom));
        adj = (kind == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
        sendFrame(p, adj);
        if (adj != 8'h00) begin
          expErr++;
          expCode = 2'd2;
          chk("rnd_csum_err", frame_err_o, 1);
          idle(2);
          chk("rnd_csum_no_valid", validCycles, 0);
        end else begin
          expOk++;
          chk("rnd_ok", frame_ok_o, 1);
          drainAll(1);
          checkStream("rnd", p);
        end
      end
      chkCounts("rnd");
    end

    // reset in the middle of a drain
    out_ready_i = 1'b0;
    p = '{8'h01, 8'h02, 8'h03};
    sendFrame(p, 8'h00);
    idle(2);
    chk("rst_pre_valid", out_valid_o, 1);
    #2 resetn = 1'b0;
    #1 chkQuiet("rst_mid");
    @(posedge clk16x); #1;
    resetn = 1'b1;
    expOk = 0;
    expErr = 0;
    expCode = 2'd0;
    idle(3);
    chk("rst_post_valid", out_valid_o, 0);
    out_ready_i = 1'b1;
    clearMon();
    p = '{8'h77};
    sendFrame(p, 8'h00);
    expOk++;
    chk("rst_new_ok", frame_ok_o, 1);
    drainAll(0);
    checkStream("rst_new", p);
    chkCounts("rst_new");

    // error counter saturation
    force dut.err_count_o = 16'hFFFE;
    #1 release dut.err_count_o;
    sendByte(SOF); sendByte(8'h00);
    chk("sat_reach", err_count_o, 16'hFFFF);
    sendByte(SOF); sendByte(8'h00);
    chk("sat_hold", err_count_o, 16'hFFFF);
    chk("sat_err_pulse", frame_err_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/vlc_frame_rx_ctrl.md
Name: vlc_frame_rx_ctrl

Overview:
Frame-level receive controller behind the Manchester decoder in the VLC receive path. It consumes decoded bytes, hunts for start-of-frame, and checks length and checksum. It buffers the payload and releases good frames to downstream logic over a valid/ready byte stream. It also reports per-frame errors and keeps saturating good/bad frame counters.

Parameters:
MAX_LEN, 32, maximum payload bytes per frame and buffer depth (2..255).
TIMEOUT, 2000, idle clk16x cycles allowed between bytes inside a frame.
SOF, 8'hA5, start-of-frame byte.

Ports:
clk16x  input  1  receive clock, same clock as the decoder.
resetn  input  1  asynchronous active-low reset.
byte_i  input  8  decoded byte from the decoder.
byte_valid_i  input  1  single-cycle strobe; byte_i is valid this cycle.
recv_err_i  input  1  decoder symbol-error strobe.
out_data_o  output  8  payload byte.
out_valid_o  output  1  out_data_o is valid.
out_last_o  output  1  final payload byte of the frame.
out_ready_i  input  1  downstream accepts the byte.
frame_ok_o  output  1  one-cycle pulse when a frame passes its checks.
frame_err_o  output  1  one-cycle pulse when a frame is aborted.
err_code_o  output  2  0 line error, 1 bad length, 2 checksum, 3 timeout; held until the next frame_err_o.
overrun_o  output  1  one-cycle pulse when a byte is dropped during DRAIN.
ok_count_o  output  16  good frames received, saturating at 16'hFFFF.
err_count_o  output  16  aborted frames, saturating at 16'hFFFF.

Behaviour:
- Reset values: every output is 0, the state is IDLE, and all pointers, counters and the running checksum are 0. Reset asserted mid-frame or mid-drain discards the buffered frame immediately.
- Frame format on the wire: SOF, LEN, LEN payload bytes, CSUM. CSUM equals the XOR of LEN and all payload bytes.
- IDLE: a byte equal to SOF moves the state to LEN. Any other byte is ignored. recv_err_i is ignored in IDLE.
- LEN: if LEN is 0 or greater than MAX_LEN, abort with code 1. Otherwise latch LEN, set the checksum to LEN, clear the write pointer and go to PAYLOAD.
- PAYLOAD: each byte is written to buf[wr_ptr], XORed into the checksum, and wr_ptr increments. When wr_ptr reaches LEN, go to CSUM.
- CSUM: if the byte equals the running checksum, pulse frame_ok_o, increment ok_count_o and go to DRAIN with rd_ptr cleared. On mismatch, abort with code 2.
- DRAIN:
  - out_valid_o = 1, out_data_o = buf[rd_ptr], out_last_o = 1 when rd_ptr == LEN-1.
  - rd_ptr advances on out_valid_o && out_ready_i. The handshake on the last byte returns the state to IDLE.
  - out_data_o and out_last_o are stable while out_valid_o && !out_ready_i.
  - Any byte_valid_i during DRAIN is dropped and pulses overrun_o. recv_err_i is ignored.
- Abort: pulse frame_err_o, load err_code_o, increment err_count_o and return to IDLE. Buffer contents are not emitted.
- Line error: recv_err_i in LEN, PAYLOAD or CSUM aborts with code 0.
- Timeout: the idle counter clears on every accepted byte and on entry to LEN. It counts in LEN, PAYLOAD and CSUM. Reaching TIMEOUT consecutive cycles without byte_valid_i aborts with code 3.
- Simultaneous events:
  - recv_err_i together with byte_valid_i: the error wins and the byte is discarded.
  - byte_valid_i in the cycle the timeout would fire: the byte wins.
  - Abort and its return to IDLE occur in the same edge. A SOF arriving the very next cycle is accepted.
- Latency: frame_ok_o and out_valid_o both rise one clk16x edge after the CSUM strobe cycle. Throughput is one byte per cycle out of DRAIN.
- Buffer: MAX_LEN x 8 register array, single write port and single read port. No read-during-write hazard, because writes occur only outside DRAIN.
- Counter widths: the pointers and the LEN register are clog2(MAX_LEN+1) bits.

Test Plan:
- Good frame: bytes A5,03,11,22,33,03 with out_ready_i=1. Required: frame_ok_o pulses once; output stream is 11,22,33 with out_last_o on 33; ok_count_o=1.
- Backpressure: same frame, out_ready_i low for 5 cycles after out_valid_o rises. Required: out_data_o holds at 11, no bytes lost. Also send byte 55 during DRAIN. Required: overrun_o pulses once and the stream is unchanged.
- Bad checksum: bytes A5,02,01,02,00 (expected 01). Required: frame_err_o pulses, err_code_o=2, err_count_o=1, out_valid_o never asserts.
- Length bounds: A5,00 gives err_code_o=1. A5 followed by MAX_LEN+1 (33) gives err_code_o=1. A5 followed by 32 bytes plus a correct CSUM is accepted and drains 32 bytes.
- Timeout and line error: A5,04,AA then silence for TIMEOUT cycles gives err_code_o=3 exactly at cycle 2000. A5,02 followed by recv_err_i gives err_code_o=0. A5 on the next cycle after either abort starts a new frame.
- Reset and saturation: assert resetn low during DRAIN. Required: all outputs 0 and the state is IDLE. Force err_count_o to FFFF and abort once more. Required: err_count_o stays FFFF.
